// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and write-mux selects shared by the sequencer files
package alu_seq_pkg;
  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR = 4'h4,
                         OP_XOR = 4'h5, OP_OUT = 4'h6, OP_IN = 4'h7, OP_MOV = 4'h8, OP_LDI = 4'h9,
                         OP_JMP = 4'hA, OP_BRZ = 4'hB, OP_BRN = 4'hC, OP_HALT = 4'hF;
  localparam logic [1:0] WSEL_ALU = 2'b00, WSEL_IMM = 2'b01, WSEL_IN = 2'b10;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_IMM_FETCH, S_IMM, S_WAIT_IN, S_WAIT_OUT, S_HALT
  } state_t;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: classifies a 4-bit opcode into the control classes the FSM needs
module alu_seq_decode import alu_seq_pkg::*; (
  input  logic [3:0] op,
  output logic       writes_reg,
  output logic       is_alu,
  output logic       needs_imm,
  output logic       is_branch,
  output logic       is_io
);
  always_comb begin
    is_alu = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV};
    is_io = op inside {OP_OUT, OP_IN};
    is_branch = op inside {OP_BRZ, OP_BRN};
    needs_imm = is_branch | (op inside {OP_LDI, OP_JMP});
    writes_reg = is_alu | (op inside {OP_LDI, OP_IN});
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute FSM for the 8-bit datapath (ALU_SEQ_RETIRE_CNT_EN adds retire_cnt)
module alu_sequencer import alu_seq_pkg::*; #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  output logic [3:0]        alu_sel,
  input  logic [7:0]        alu_result,
  output logic [1:0]        ra_addr,
  output logic [1:0]        rb_addr,
  output logic              reg_we,
  output logic [1:0]        reg_wsel,
  output logic [7:0]        imm,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              flag_n,
  output logic              flag_z,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
`ifdef ALU_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]       retire_cnt
`endif
);
  state_t state, nxt;
  logic [7:0] ir;
  logic [3:0] op;
  logic writes_reg, is_alu, needs_imm, is_branch, is_io, taken;
  assign op = state == S_DECODE ? imem_rdata[7:4] : ir[7:4];
  assign taken = (op == OP_BRZ & flag_z) | (op == OP_BRN & flag_n);
  assign imem_addr = pc;
  assign ra_addr = ir[3:2];
  assign rb_addr = ir[1:0];
  assign halted = state == S_HALT;
  assign imm = state == S_IMM ? imem_rdata : '0;
  alu_seq_decode u_dec (
    .op(op), .writes_reg(writes_reg), .is_alu(is_alu), .needs_imm(needs_imm),
    .is_branch(is_branch), .is_io(is_io)
  );
  always_comb begin
    nxt = state;
    alu_sel = OP_NOP;
    reg_we = 1'b0;
    reg_wsel = WSEL_ALU;
    in_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: nxt = is_alu ? S_EXEC : is_io ? (op == OP_IN ? S_WAIT_IN : S_WAIT_OUT) :
                      (needs_imm & (taken | !is_branch)) ? S_IMM_FETCH : op == OP_HALT ? S_HALT : S_FETCH;
      S_EXEC: begin
        alu_sel = op;
        reg_we = 1'b1;
        nxt = S_FETCH;
      end
      S_IMM_FETCH: nxt = S_IMM;
      S_IMM: begin
        reg_we = writes_reg;
        reg_wsel = WSEL_IMM;
        nxt = S_FETCH;
      end
      S_WAIT_IN: begin
        in_ready = 1'b1;
        reg_we = in_valid;
        reg_wsel = WSEL_IN;
        nxt = in_valid ? S_FETCH : S_WAIT_IN;
      end
      S_WAIT_OUT: begin
        alu_sel = OP_OUT;
        out_valid = 1'b1;
        nxt = out_ready ? S_FETCH : S_WAIT_OUT;
      end
      default: nxt = S_HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      ir <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        ir <= imem_rdata;
        pc <= pc + ((is_branch & !taken) ? ADDR_W'(2) : ADDR_W'(1));
      end
      if (state == S_IMM) pc <= writes_reg ? pc + ADDR_W'(1) : ADDR_W'(imem_rdata);
      if (state == S_EXEC) begin
        flag_n <= alu_result[7];
        flag_z <= alu_result == '0;
      end
    end
  end
`ifdef ALU_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) retire_cnt <= '0;
    else if (nxt == S_FETCH || (nxt == S_HALT && state != S_HALT)) retire_cnt <= retire_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed and random programs checked against an instruction-level model
module tb_alu_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0] imem_addr, imem_rdata, alu_result, imm, pc;
  logic [3:0] alu_sel;
  logic [1:0] ra_addr, rb_addr, reg_wsel;
  logic reg_we, in_ready, out_valid, flag_n, flag_z, halted;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif
  logic [7:0] rom [256];
  logic [7:0] regs [4] = '{default: 8'h00};
  logic [7:0] mr [4] = '{default: 8'h00};
  logic [7:0] prog [$];
  logic [7:0] mpc;
  logic mn, mz;
  int mret, n_tests = 0, n_fail = 0, cyc = 0, lo_cnt = 0, alu_cyc = 0, halt_cyc = 0;
  alu_sequencer dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .alu_sel(alu_sel),
    .alu_result(alu_result), .ra_addr(ra_addr), .rb_addr(rb_addr), .reg_we(reg_we),
    .reg_wsel(reg_wsel), .imm(imm), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flag_n(flag_n), .flag_z(flag_z),
    .halted(halted), .pc(pc)
`ifdef ALU_SEQ_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );
  function automatic logic [7:0] alu_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
    case (s)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return a;
      4'd8: return b;
      default: return 8'h00;
    endcase
  endfunction
  assign alu_result = alu_f(alu_sel, regs[ra_addr], regs[rb_addr]);
  always @(posedge clk) imem_rdata <= rom[imem_addr];
  always @(posedge clk)
    if (reg_we) regs[ra_addr] <= reg_wsel == 2'b00 ? alu_result : reg_wsel == 2'b01 ? imm : in_data;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
    if (lo_cnt > 0) begin
      lo_cnt--;
      in_valid = 1'b0;
      out_ready = 1'b0;
    end else begin
      in_valid = $urandom_range(0, 2) == 0;
      out_ready = $urandom_range(0, 2) == 0;
    end
    in_data = 8'($urandom);
    @(negedge clk);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 1;
    lo_cnt = 0;
    mpc = 8'h00;
    mn = 1'b0;
    mz = 1'b0;
    mret = 0;
    @(negedge clk);
  endtask
  task automatic load();
    for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    foreach (prog[i]) rom[i] = prog[i];
  endtask
  task automatic step_instr(output bit stop);
    logic [7:0] ins, b;
    logic [3:0] op;
    logic [1:0] a, r;
    bit done, tk;
    ins = rom[mpc];
    op = ins[7:4];
    a = ins[3:2];
    r = ins[1:0];
    b = rom[8'(mpc + 8'd1)];
    stop = 1'b0;
    done = 1'b0;
    chk("pc", pc, mpc);
    chk("imem_addr", imem_addr, mpc);
    chk("flag_n", flag_n, mn);
    chk("flag_z", flag_z, mz);
    for (int i = 0; i < 4; i++) chk("reg", regs[i], mr[i]);
    chk("fetch_strobes", {reg_we, in_ready, out_valid, halted, alu_sel}, 8'h00);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, 16'(mret));
`endif
    next();
    chk("decode_strobes", {reg_we, in_ready, out_valid, halted, alu_sel}, 8'h00);
    if (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8}) begin
      next();
      alu_cyc = cyc;
      chk("exec", {alu_sel, reg_we, reg_wsel, ra_addr}, {op, 1'b1, 2'b00, a});
      mr[a] = alu_f(op, mr[a], mr[r]);
      mn = mr[a][7];
      mz = mr[a] == 8'h00;
      mpc = mpc + 8'd1;
    end else if (op == 4'd7) begin
      for (int k = 0; k < 40 && !done; k++) begin
        next();
        chk("in_ready", {in_ready, out_valid, alu_sel}, 6'b100000);
        if (in_valid) begin
          chk("in_write", {reg_we, reg_wsel, ra_addr}, {1'b1, 2'b10, a});
          mr[a] = in_data;
          done = 1'b1;
        end else chk("in_hold_we", reg_we, 1'b0);
      end
      if (!done) chk("in_timeout", 1'b0, 1'b1);
      mpc = mpc + 8'd1;
    end else if (op == 4'd6) begin
      for (int k = 0; k < 40 && !done; k++) begin
        next();
        chk("out_hold", {out_valid, in_ready, reg_we, alu_sel, ra_addr}, {3'b100, 4'd6, a});
        chk("out_data", alu_result, mr[a]);
        done = out_ready;
      end
      if (!done) chk("out_timeout", 1'b0, 1'b1);
      mpc = mpc + 8'd1;
    end else if (op inside {4'd9, 4'd10, 4'd11, 4'd12}) begin
      tk = op == 4'd9 || op == 4'd10 || (op == 4'd11 && mz) || (op == 4'd12 && mn);
      if (tk) begin
        next();
        chk("imm_fetch", {imem_addr, reg_we, alu_sel}, {8'(mpc + 8'd1), 1'b0, 4'd0});
        next();
        if (op == 4'd9) begin
          chk("ldi", {reg_we, reg_wsel, imm, ra_addr}, {1'b1, 2'b01, b, a});
          mr[a] = b;
          mpc = mpc + 8'd2;
        end else begin
          chk("jmp_we", {reg_we, alu_sel}, 5'd0);
          mpc = b;
        end
      end else mpc = mpc + 8'd2;
    end else if (op == 4'hF) begin
      next();
      halt_cyc = cyc;
      mpc = mpc + 8'd1;
      mret++;
      for (int k = 0; k < 3; k++) begin
        chk("halt", {halted, pc, reg_we, in_ready, out_valid, alu_sel}, {1'b1, mpc, 7'd0});
`ifdef ALU_SEQ_RETIRE_CNT_EN
        chk("halt_retire", retire_cnt, 16'(mret));
`endif
        next();
      end
      stop = 1'b1;
      return;
    end else mpc = mpc + 8'd1;
    mret++;
    next();
  endtask
  task automatic run(input int n);
    bit stop;
    stop = 1'b0;
    for (int i = 0; i < n && !stop; i++) step_instr(stop);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    prog = {8'h90, 8'h05, 8'h94, 8'h03, 8'h11, 8'hF0};
    load();
    do_reset();
    chk("reset_state", {pc, halted, flag_n, flag_z, reg_we, in_ready, out_valid, alu_sel}, 16'h0000);
    chk("reset_imm", imm, 8'h00);
    run(10);
    chk("add_cycle", 16'(alu_cyc), 16'd11);
    chk("halt_cycle", 16'(halt_cyc), 16'd14);
    chk("halt_pc", pc, 8'h06);
    chk("add_r0", regs[0], 8'h08);
    prog = {8'h90, 8'h04, 8'h94, 8'h04, 8'h21, 8'hB0, 8'h20};
    load();
    rom[8'h20] = 8'hF0;
    do_reset();
    run(10);
    chk("brz_taken_pc", pc, 8'h21);
    chk("sub_z", flag_z, 1'b1);
    do_reset();
    chk("rst_in_halt", {halted, flag_n, flag_z, pc}, 11'd0);
    prog = {8'h90, 8'h04, 8'h94, 8'h03, 8'h21, 8'hB0, 8'h20, 8'hF0};
    load();
    do_reset();
    run(10);
    chk("brz_not_taken_pc", pc, 8'h08);
    prog = {8'h70, 8'hF0};
    load();
    do_reset();
    lo_cnt = 6;
    run(4);
    prog = {8'h90, 8'hA5, 8'h60, 8'hF0};
    load();
    do_reset();
    lo_cnt = 9;
    run(4);
    prog = {8'h60};
    load();
    do_reset();
    lo_cnt = 10;
    for (int k = 0; k < 3; k++) next();
    chk("wait_out", {out_valid, alu_sel}, {1'b1, 4'd6});
    do_reset();
    chk("rst_in_wait_out", {out_valid, pc, halted, flag_n, flag_z}, 12'd0);
    prog = {8'hA0, 8'hFE};
    load();
    rom[8'hFE] = 8'h00;
    rom[8'hFF] = 8'h00;
    do_reset();
    run(8);
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      do_reset();
      run(30);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
